// File: rtl/quad_gen_if.sv
// -----------------------------------------------------------------------------
// quad_gen_if -- command channel of the quadrature pulse generator.
//
// Groups the valid/ready command handshake, the command payload and the abort
// request into one bundle.
//   cmd_valid  : command offered (master -> slave)
//   cmd_ready  : command can be accepted (slave -> master)
//   cmd_dir    : 1 = clockwise (A leads B), 0 = counter-clockwise
//   cmd_steps  : number of quadrature edges to emit, CNT_W bits
//   cmd_period : clocks between edges, DIV_W bits, 0 behaves as 1
//   abort      : terminate the running command
// -----------------------------------------------------------------------------
interface quad_gen_if #(
  parameter int CNT_W = 12,
  parameter int DIV_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_steps;
  logic [DIV_W-1:0] cmd_period;
  logic             abort;

  modport master (
    output cmd_valid, cmd_dir, cmd_steps, cmd_period, abort,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_steps, cmd_period, abort,
    output cmd_ready
  );
endinterface

// File: rtl/quad_gen.sv
// -----------------------------------------------------------------------------
// quad_gen -- quadrature pulse generator.
//
// Turns a commanded step count, direction and step period into registered A/B
// quadrature waveforms in the PmodENC format, and tracks a signed position.
//
// Ports:
//   clk_100MHz : system clock
//   reset_n    : asynchronous active-low reset
//   cmd        : quad_gen_if.slave command channel (valid/ready, dir, steps,
//                period, abort)
//   A, B       : quadrature outputs, registered
//   Z          : index pulse, registered (constant 0 without the index feature)
//   busy       : command in progress
//   done       : one-cycle completion pulse (normal end, abort or zero steps)
//   pos        : signed position counter, wraps modulo 2^CNT_W
//
// Optional feature: define QUAD_GEN_INDEX_EN to add the index counter, which
// wraps over INDEX_DIV edges and raises Z whenever the post-edge count is 0.
// -----------------------------------------------------------------------------
module quad_gen #(
  parameter int CNT_W     = 12,
  parameter int DIV_W     = 16,
  parameter int INDEX_DIV = 80
) (
  input  logic             clk_100MHz,
  input  logic             reset_n,
  quad_gen_if.slave        cmd,
  output logic             A,
  output logic             B,
  output logic             Z,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pos
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t           state_q, state_d;

  logic             dir_q;
  logic [CNT_W-1:0] steps_q;    // edges still to emit
  logic [DIV_W-1:0] reload_q;   // P-1 for the running command
  logic [DIV_W-1:0] per_cnt_q;  // clocks until the next edge, 0 = edge due
  logic [DIV_W-1:0] reload_d;

  logic             accept;
  logic             edge_fire;
  logic             finish;

  // Period 0 is treated as 1, so both reload with 0 (an edge every clock).
  assign reload_d = (cmd.cmd_period == '0) ? '0 : cmd.cmd_period - DIV_W'(1);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM next state and control strobes
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    edge_fire     = 1'b0;
    finish        = 1'b0;
    busy          = 1'b0;
    cmd.cmd_ready = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cmd.cmd_ready = 1'b1;
        // abort has no meaning in IDLE; a command offered with it is taken.
        if (cmd.cmd_valid) begin
          accept = 1'b1;
          if (cmd.cmd_steps == '0) finish  = 1'b1;
          else                     state_d = S_RUN;
        end
      end

      S_RUN: begin
        busy = 1'b1;
        if (cmd.abort) begin
          // Abort wins over an edge due on the same clock.
          state_d = S_IDLE;
          finish  = 1'b1;
        end else if (per_cnt_q == '0) begin
          edge_fire = 1'b1;
          if (steps_q == CNT_W'(1)) begin
            state_d = S_IDLE;
            finish  = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Command latch, step counter and period counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      dir_q     <= 1'b0;
      steps_q   <= '0;
      reload_q  <= '0;
      per_cnt_q <= '0;
    end else if (accept) begin
      dir_q     <= cmd.cmd_dir;
      steps_q   <= cmd.cmd_steps;
      reload_q  <= reload_d;
      per_cnt_q <= reload_d;
    end else if (edge_fire) begin
      steps_q   <= steps_q - CNT_W'(1);
      per_cnt_q <= reload_q;
    end else if (state_q == S_RUN) begin
      per_cnt_q <= per_cnt_q - DIV_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Quadrature outputs, position and completion pulse
  // ---------------------------------------------------------------------------
  // The phase is never reset between commands: each command continues the
  // Gray sequence from the current AB value.
  //   clockwise        AB: 00 -> 10 -> 11 -> 01 -> 00   (next = {~B, A})
  //   counter-clockwise AB: 00 -> 01 -> 11 -> 10 -> 00  (next = {B, ~A})
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      A    <= 1'b0;
      B    <= 1'b0;
      pos  <= '0;
      done <= 1'b0;
    end else begin
      done <= finish;
      if (edge_fire) begin
        if (dir_q) begin
          A   <= ~B;
          B   <= A;
          pos <= pos + CNT_W'(1);
        end else begin
          A   <= B;
          B   <= ~A;
          pos <= pos - CNT_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional index pulse
  // ---------------------------------------------------------------------------
`ifdef QUAD_GEN_INDEX_EN
  localparam int IDX_W = (INDEX_DIV > 1) ? $clog2(INDEX_DIV) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(INDEX_DIV - 1);

  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    if (dir_q) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
    else       idx_d = (idx_q == '0) ? IDX_MAX : idx_q - IDX_W'(1);
  end

  // Z only moves on edges, so it holds its value between them.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      idx_q <= '0;
      Z     <= 1'b0;
    end else if (edge_fire) begin
      idx_q <= idx_d;
      Z     <= (idx_d == '0);
    end
  end
`else
  // Index logic compiled out; INDEX_DIV has no effect in this build.
  logic unused_index_div;
  assign unused_index_div = ^INDEX_DIV;
  assign Z = 1'b0;
`endif

endmodule
